// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between an MDU client and the mdu block
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with HI/LO registers and fixed-latency busy window
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [2*WIDTH-1:0]      prod_u;
    logic signed [2*WIDTH-1:0] prod_s;
    logic                    b_zero;
    logic                    div_ovf;
    logic [WIDTH-1:0]        b_safe;
    logic signed [WIDTH-1:0] q_s, r_s;
    logic [WIDTH-1:0]        q_u, r_u;
    logic [WIDTH-1:0]        res_hi, res_lo;
    logic                    res_wr;

    // Results come from the latched operands and are only consumed on the last busy cycle.
    assign prod_s  = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign b_zero  = (b_q == '0);
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    assign b_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    assign q_s     = $signed(a_q) / $signed(b_safe);
    assign r_s     = $signed(a_q) % $signed(b_safe);
    assign q_u     = a_q / b_safe;
    assign r_u     = a_q % b_safe;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        case (op_q)
            3'd0: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
                res_wr = 1'b1;
            end
            3'd1: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
                res_wr = 1'b1;
            end
            3'd2: begin
                // Most-negative / -1 wraps the quotient and leaves no remainder.
                res_hi = div_ovf ? '0 : r_s;
                res_lo = div_ovf ? a_q : q_s;
                res_wr = !b_zero;
            end
            3'd3: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = !b_zero;
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d = RUN;
                            cnt_d   = bus.op[1] ? DIV_N : MULT_N;
                            op_d    = bus.op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                        end
                        3'd4:    hi_d = bus.a;
                        3'd5:    lo_d = bus.a;
                        default: state_d = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized and directed self-checking bench for mdu
module tb_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mdu #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          chk_en   = 1'b0;

    longint      cyc      = 0;
    longint      done_at  = 0;
    bit          m_busy   = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_wr = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_result(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, output logic [W-1:0] h,
                                         output logic [W-1:0] l, output bit wr);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        logic [63:0]     q;
        logic [63:0]     r;
        h = m_hi; l = m_lo; wr = 1'b0;
        case (op)
            3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; wr = 1'b1; end
            3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; wr = 1'b1; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; wr = 1'b1; end
            3'd3: if (b != 0) begin q = ua / ub; r = ua % ub; l = q[31:0]; h = r[31:0]; wr = 1'b1; end
            default: wr = 1'b0;
        endcase
    endfunction

    // Reference: an accepted op owns the unit until done_at, when its result lands.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_busy) begin
            if (cyc == done_at) begin
                m_busy = 1'b0;
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (bus.start) begin
            case (bus.op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    m_busy  = 1'b1;
                    done_at = cyc + ((bus.op < 3'd2) ? 5 : 10);
                    model_result(bus.op, bus.a, bus.b, p_hi, p_lo, p_wr);
                end
                3'd4:    m_hi = bus.a;
                3'd5:    m_lo = bus.a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            4:       return -32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout: busy still %b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        reset = 1'b1;

        issue(3'd0, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("multu_hi", bus.hi, 32'h1);
        check("multu_lo", bus.lo, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'h2);
        wait_idle(n);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(3'd2, 32'd5, 32'd0);
        wait_idle(n);
        check("div0_cycles", 32'(n), 32'd10);
        check("div0_hi", bus.hi, 32'h1234_5678);
        check("div0_lo", bus.lo, 32'd3);

        issue(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);
        check("mtlo_ignored_hi", bus.hi, 32'd0);
        check("mtlo_ignored_lo", bus.lo, 32'h0000_000C);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", bus.lo, 32'h8000_0000);
        check("divovf_hi", bus.hi, 32'd0);

        issue(3'd6, 32'h5555_5555, 32'd1);
        check("reserved_busy", {31'd0, bus.busy}, 32'd0);
        check("reserved_lo", bus.lo, 32'h8000_0000);

        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_late_hi", bus.hi, 32'd0);
        check("abort_late_lo", bus.lo, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset     = ($urandom % 250) != 0;
            bus.start = ($urandom % 3) == 0;
            bus.op    = 3'($urandom);
            bus.a     = pick();
            bus.b     = pick();
        end
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b0;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of each of HI and LO.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU; legal range 1..255.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 start  input  1  operation request, sampled each rising edge.
REQ-007 op  input  3  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-008 a  input  WIDTH  first operand (multiplicand/dividend); MTHI/MTLO data.
REQ-009 b  input  WIDTH  second operand (multiplier/divisor).
REQ-010 busy  output  1  high while a multiply/divide is in flight.
REQ-011 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-013 FSM states IDLE and RUN; busy = 1 exactly when state is RUN.
REQ-014 IDLE, start=1, op in {0..3}: latch a, b, op on that edge; enter RUN; load down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 busy goes high the edge after the start edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 hi/lo update on the edge where busy falls; same edge returns to IDLE; a new start is accepted on the next edge.
REQ-017 hi/lo hold their previous values for the whole RUN interval.
REQ-018 MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-019 MULTU: identical to MULT with unsigned operands.
REQ-020 DIV: signed; quotient truncated toward zero into lo; remainder into hi, remainder sign equals dividend sign.
REQ-021 DIVU: unsigned quotient into lo, remainder into hi.
REQ-022 DIV of most-negative value by -1: lo = most-negative value (wrap), hi = 0.
REQ-023 Division with b = 0 (DIV or DIVU): full busy sequence runs; hi and lo left unchanged at completion.
REQ-024 IDLE, start=1, op=4 (MTHI): hi <= a on that edge; lo unchanged; busy stays 0.
REQ-025 IDLE, start=1, op=5 (MTLO): lo <= a on that edge; hi unchanged; busy stays 0.
REQ-026 start=1 with op 6 or 7: ignored; no state change.
REQ-027 start=1 while RUN (any op, including MTHI/MTLO): ignored; in-flight operation unaffected.
REQ-028 Inputs a, b, op may change freely during RUN; only values latched at the start edge are used.
REQ-029 Result computation method (combinational, iterative, or pipelined) is free provided the timing in REQ-015/016 is met exactly.

Reset
REQ-030 reset=0 at a rising edge: state <= IDLE, busy <= 0, hi <= 0, lo <= 0, counter <= 0, latched operands <= 0.
REQ-031 Reset during RUN aborts the operation; no result is ever written for it.
REQ-032 Reset has priority over start on the same edge.

Verification
REQ-033 MULT a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-034 MULTU a=0xFFFFFFFF, b=0x00000002 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-036 MTHI a=0x12345678 then DIV a=5, b=0 -> hi=0x12345678 immediately; after 10 busy cycles hi still 0x12345678, lo unchanged.
REQ-037 MULT 3x4 started, MTLO a=0xDEADBEEF issued on 2nd busy cycle -> MTLO ignored; at completion hi=0, lo=0x0000000C.
REQ-038 DIV started, reset=0 on 4th busy cycle -> next cycle busy=0, hi=0, lo=0; no later update after release.
